// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes.
// Hits complete in the request cycle; misses stall through WRITEBACK/ALLOCATE.
module dcache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e state_q, state_d;

  logic [NUM_LINES-1:0]           valid_q, dirty_q;
  logic [NUM_LINES-1:0][2:0]      tag_q;
  logic [NUM_LINES-1:0][3:0][7:0] data_q;

  logic [2:0]      tag, idx;
  logic [1:0]      off;
  logic            req, hit, fill, wr_hit;
  logic [3:0][7:0] blk;

  assign tag = ADDRESS[7:5];
  assign idx = ADDRESS[4:2];
  assign off = ADDRESS[1:0];
  assign req = READ | WRITE;
  assign hit = valid_q[idx] & (tag_q[idx] == tag);
  assign blk = data_q[idx];

  assign BUSYWAIT = req & ~((state_q == IDLE) & hit);
  assign wr_hit   = WRITE & ~BUSYWAIT;
  assign READDATA = READ ? blk[off] : 8'h00;

  always_comb begin
    state_d       = state_q;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = ADDRESS[7:2];
    MEM_WRITEDATA = blk;
    fill          = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !hit)
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {tag_q[idx], idx};
        if (!MEM_BUSYWAIT) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Reset also blocks array writes so an abandoned refill leaves the line untouched.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (fill) begin
        data_q[idx] <= MEM_READDATA;
        tag_q[idx]  <= tag;
      end else if (wr_hit) begin
        data_q[idx][off] <= WRITEDATA;
      end
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache with a fixed-latency block memory model.
module tb_dcache;
  localparam int LAT = 5;

  logic        CLK, RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  dcache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory: fixed initial contents, overridden by completed block writes.
  function automatic logic [31:0] rom(input logic [5:0] a);
    case (a)
      6'h09:   rom = 32'h44332211;
      6'h39:   rom = 32'hDDCCBBAA;
      6'h00:   rom = 32'h87654321;
      6'h38:   rom = 32'h0F0E0D0C;
      6'h11:   rom = 32'h55667788;
      default: rom = {26'h0, a};
    endcase
  endfunction

  bit          wflag [64];
  logic [31:0] wmem  [64];
  int          cnt = 0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt < LAT - 1);
  assign MEM_READDATA = wflag[MEM_ADDRESS] ? wmem[MEM_ADDRESS] : rom(MEM_ADDRESS);

  always @(posedge CLK) begin
    if ((MEM_READ | MEM_WRITE) && MEM_BUSYWAIT) cnt <= cnt + 1;
    else                                         cnt <= 0;
    if (MEM_WRITE && !MEM_BUSYWAIT) begin
      wflag[MEM_ADDRESS] <= 1'b1;
      wmem[MEM_ADDRESS]  <= MEM_WRITEDATA;
    end
  end

  int n_cmp = 0, n_err = 0;
  int stall;
  logic [7:0]  rdata;
  logic        saw_rd, saw_wr, both = 1'b0;
  logic [5:0]  rd_addr, wb_addr;
  logic [31:0] wb_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and hold it until BUSYWAIT drops, logging memory traffic.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd);
    bit done = 0;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    stall = 0; saw_rd = 0; saw_wr = 0; rd_addr = '0; wb_addr = '0; wb_data = '0;
    rdata = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (MEM_READ && MEM_WRITE) both = 1'b1;
      if (MEM_READ && !saw_rd) begin saw_rd = 1; rd_addr = MEM_ADDRESS; end
      if (MEM_WRITE && !saw_wr) begin
        saw_wr = 1; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA;
      end
      if (!BUSYWAIT) begin
        rdata = READDATA;
        done = 1;
        break;
      end
      stall++;
    end
    if (!done) chk("req_timeout", 32'(done), 32'd1);
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
  endtask

  initial begin
    RESET = 1; READ = 0; WRITE = 0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
    chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_readdata", 32'(READDATA), 32'h00);

    // Clean miss, then hits to the refilled line.
    do_req(1, 0, 8'h24, 8'h00);
    chk("miss24_stall", 32'(stall), 32'd6);
    chk("miss24_addr", 32'(rd_addr), 32'h09);
    chk("miss24_data", 32'(rdata), 32'h11);
    chk("miss24_no_wb", 32'(saw_wr), 32'd0);

    do_req(1, 0, 8'h27, 8'h00);
    chk("hit27_stall", 32'(stall), 32'd0);
    chk("hit27_data", 32'(rdata), 32'h44);
    chk("hit27_no_rd", 32'(saw_rd), 32'd0);

    do_req(0, 1, 8'h26, 8'hAB);
    chk("wr26_stall", 32'(stall), 32'd0);
    chk("wr26_no_traffic", 32'({saw_rd, saw_wr}), 32'd0);

    do_req(1, 0, 8'h26, 8'h00);
    chk("rd26_data", 32'(rdata), 32'hAB);
    chk("rd26_stall", 32'(stall), 32'd0);

    // Conflict miss on a dirty line: writeback then refill.
    do_req(1, 0, 8'hE4, 8'h00);
    chk("missE4_stall", 32'(stall), 32'd11);
    chk("missE4_wb_seen", 32'(saw_wr), 32'd1);
    chk("missE4_wb_addr", 32'(wb_addr), 32'h09);
    chk("missE4_wb_data", wb_data, 32'h44AB2211);
    chk("missE4_rd_addr", 32'(rd_addr), 32'h39);
    chk("missE4_data", 32'(rdata), 32'hAA);

    // Reset in the middle of a refill.
    @(posedge CLK); #1;
    READ = 1; ADDRESS = 8'h44;
    @(negedge CLK);
    chk("abort_idle_busy", 32'(BUSYWAIT), 32'd1);
    chk("abort_idle_memrd", 32'(MEM_READ), 32'd0);
    @(negedge CLK);
    chk("abort_alloc_memrd", 32'(MEM_READ), 32'd1);
    chk("abort_alloc_addr", 32'(MEM_ADDRESS), 32'h11);
    RESET = 1;
    @(negedge CLK);
    chk("abort_memrd_drop", 32'(MEM_READ), 32'd0);
    chk("abort_memwr_drop", 32'(MEM_WRITE), 32'd0);
    chk("abort_still_miss", 32'(BUSYWAIT), 32'd1);
    RESET = 0; READ = 0;
    @(negedge CLK);
    chk("abort_idle_quiet", 32'(BUSYWAIT), 32'd0);

    do_req(1, 0, 8'h44, 8'h00);
    chk("reissue44_stall", 32'(stall), 32'd6);
    chk("reissue44_addr", 32'(rd_addr), 32'h11);
    chk("reissue44_data", 32'(rdata), 32'h88);

    // Written-back block must come back from memory.
    do_req(1, 0, 8'h26, 8'h00);
    chk("reload26_stall", 32'(stall), 32'd6);
    chk("reload26_data", 32'(rdata), 32'hAB);

    // Write miss to an invalid line, then a write hit to the dirty line.
    do_req(0, 1, 8'h03, 8'h5A);
    chk("wmiss03_stall", 32'(stall), 32'd6);
    chk("wmiss03_addr", 32'(rd_addr), 32'h00);
    chk("wmiss03_no_wb", 32'(saw_wr), 32'd0);

    do_req(0, 1, 8'h00, 8'h77);
    chk("wdirty00_stall", 32'(stall), 32'd0);
    chk("wdirty00_no_traffic", 32'({saw_rd, saw_wr}), 32'd0);

    do_req(1, 0, 8'h03, 8'h00);
    chk("rd03_data", 32'(rdata), 32'h5A);
    do_req(1, 0, 8'h00, 8'h00);
    chk("rd00_data", 32'(rdata), 32'h77);
    do_req(1, 0, 8'h01, 8'h00);
    chk("rd01_data", 32'(rdata), 32'h43);

    do_req(1, 0, 8'hE3, 8'h00);
    chk("missE3_stall", 32'(stall), 32'd11);
    chk("missE3_wb_addr", 32'(wb_addr), 32'h00);
    chk("missE3_wb_data", wb_data, 32'h5A654377);
    chk("missE3_rd_addr", 32'(rd_addr), 32'h38);
    chk("missE3_data", 32'(rdata), 32'h0F);

    chk("never_both_req", 32'(both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache between the 8-bit CPU's data-memory port and the word-wide main data memory. It absorbs CPU load/store requests (lwd/lwi/swd/swi), serves hits in the request cycle and stalls the CPU via BUSYWAIT while it refills or writes back a block. Geometry is fixed: 8 blocks of 4 bytes, 256-byte CPU address space.

## Interface
- Parameters: none. Geometry is hard-wired: 8 lines, 4 bytes/line, 3-bit tag, 3-bit index, 2-bit offset.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request. READ and WRITE are never both 1.
- ADDRESS  in  8  CPU byte address: [7:5] tag, [4:2] index, [1:0] offset.
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  load data. Valid while READ=1 and BUSYWAIT=0.
- BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  block read request to memory.
- MEM_WRITE  out  1  block write request to memory.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  block data, byte 0 in [7:0].
- MEM_READDATA  in  32  refill block, byte 0 in [7:0].
- MEM_BUSYWAIT  in  1  memory busy. High in the same cycle a request rises; low in the final (data) cycle.

## Operation
- Per line storage: valid, dirty, tag[2:0], data[31:0].
- hit = valid[index] & (tag[index]==ADDRESS[7:5]).
- FSM states:
  - IDLE
    - No request: stay in IDLE.
    - Request with hit: stay in IDLE.
    - Request with miss and the indexed line dirty & valid: go to WRITEBACK.
    - Request with any other miss: go to ALLOCATE.
  - WRITEBACK
    - MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=stored block.
    - At the first posedge with MEM_BUSYWAIT=0: go to ALLOCATE.
  - ALLOCATE
    - MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
    - At the first posedge with MEM_BUSYWAIT=0: data←MEM_READDATA, tag←ADDRESS[7:5], valid←1, dirty←0, go to IDLE.
- Returning to IDLE re-evaluates the request. It is now a hit and completes normally.
- Read hit: READDATA = data[index] byte selected by ADDRESS[1:0], combinational.
- Write hit: at the posedge where BUSYWAIT=0, write the selected byte with WRITEDATA and set dirty←1. The other 3 bytes are unchanged.
- BUSYWAIT = (READ|WRITE) & ~(state==IDLE & hit). It is combinational, so a hit causes no stall.
- MEM_READ and MEM_WRITE are 0 in IDLE; MEM_ADDRESS and MEM_WRITEDATA are don't-care there.
- READDATA is don't-care when READ=0; drive 0.

## Timing
- Reset (RESET sampled 1 at posedge):
  - state←IDLE; all valid←0, dirty←0.
  - MEM_READ=MEM_WRITE=0.
  - BUSYWAIT follows its equation and is 0 with no request.
  - Data/tag arrays need not be cleared.
- Reset mid-WRITEBACK or mid-ALLOCATE: abandon immediately. Requests drop in the next cycle and the line is left invalid/unchanged (no partial refill).
- Hit latency: 0 cycles of stall.
  - Read data is valid in the request cycle.
  - Write commits at the end of the request cycle.
- Clean miss stall: 1 + Tm cycles. Tm = cycles MEM_READ is held, including its final cycle; the final IDLE cycle has BUSYWAIT=0.
- Dirty miss stall: 1 + Tw + Tm cycles.
- MEM_READ and MEM_WRITE are never both 1.
- Each request stays stable for the whole memory transaction.
- A CPU request dropped mid-miss (never by contract) still completes the current memory transaction, then returns to IDLE.
- Back-to-back requests to different lines in consecutive cycles are independent. The FSM is in IDLE at the end of every completed request.
- Write hit to a line already dirty: dirty stays 1 and no memory traffic occurs.

## Test plan
- Reset, then READ ADDRESS=0x24, memory returns 0x44332211 after Tm=5 → BUSYWAIT high for 6 cycles, MEM_ADDRESS=0x09, READDATA=0x11, line 1 valid/clean.
- Follow with READ 0x27 → BUSYWAIT=0 same cycle, READDATA=0x44, no MEM_READ.
- WRITE 0x26 data 0xAB (hit) → no stall. A subsequent READ 0x26 returns 0xAB and line 1 is dirty.
- READ 0xE4 (same index, tag 7) → WRITEBACK with MEM_ADDRESS=0x09, MEM_WRITEDATA=0x44AB2211, then ALLOCATE MEM_ADDRESS=0x39. Total stall = 1+Tw+Tm.
- Assert RESET during ALLOCATE of a miss → next cycle MEM_READ=0, state IDLE. Re-issuing the same READ misses again (valid cleared).
- WRITE miss to clean invalid line 0x03 data 0x5A → allocate, then byte 3 written, dirty=1, BUSYWAIT low only after refill.
